// File: rtl/pwr_fault_logger.sv
// pwr_fault_logger: sticky capture of sequencer faults (first fault, event count)
// with a BMC-clocked serial readout frame.
module pwr_fault_logger #(
  parameter int NUM_FLT = 7,
  parameter int CNT_W = 8,
  parameter int FRAME_W = 32,
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic [NUM_FLT-1:0] iFlt_n,
  input  logic [3:0]         iFsm_state,
  input  logic               iClear,
  input  logic               iLoad_n,
  input  logic               iSclk,
  output logic               oSdata,
  output logic               oFault_any_n,
  output logic [NUM_FLT-1:0] oFlt_latched,
  output logic [3:0]         oFirst_code,
  output logic [3:0]         oFirst_state,
  output logic [CNT_W-1:0]   oFlt_cnt,
  output logic               oBusy
);
  localparam int BW = $clog2(FRAME_W);
  localparam logic [BW-1:0] LAST = BW'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  logic [NUM_FLT-1:0] prev_q, lat_q, lat_d, edg;
  logic [3:0] code_q, code_d, fst_q, fst_d, low_code, base_code;
  logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;
  logic any_n_q, first_hit;
  logic [2:0] ld_q, sc_q;
  logic ld_fall, ld_rise, sc_rise;
  state_t st_q;
  logic [FRAME_W-1:0] sr_q, frame;
  logic [BW-1:0] bit_q;
  logic sdata_q, busy_q;
  // Clear is applied before any edge seen in the same cycle.
  always_comb begin
    edg = prev_q & ~iFlt_n;
    low_code = '0;
    for (int i = NUM_FLT - 1; i >= 0; i--) if (edg[i]) low_code = 4'(i + 1);
    base_code = iClear ? '0 : code_q;
    base_cnt = iClear ? '0 : cnt_q;
    first_hit = (base_code == '0) && |edg;
    lat_d = (iClear ? '0 : lat_q) | edg;
    code_d = first_hit ? low_code : base_code;
    fst_d = first_hit ? iFsm_state : (iClear ? '0 : fst_q);
    cnt_d = (|edg && base_cnt != CNT_MAX) ? base_cnt + CNT_W'(1) : base_cnt;
  end
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      prev_q <= '1;
      lat_q <= '0;
      code_q <= '0;
      fst_q <= '0;
      cnt_q <= '0;
      any_n_q <= 1'b1;
      ld_q <= '1;
      sc_q <= '1;
    end else begin
      prev_q <= iFlt_n;
      lat_q <= lat_d;
      code_q <= code_d;
      fst_q <= fst_d;
      cnt_q <= cnt_d;
      any_n_q <= ~|lat_q;
      ld_q <= {ld_q[1:0], iLoad_n};
      sc_q <= {sc_q[1:0], iSclk};
    end
  end
  assign ld_fall = ld_q[2] & ~ld_q[1];
  assign ld_rise = ~ld_q[2] & ld_q[1];
  assign sc_rise = ~sc_q[2] & sc_q[1];
  assign frame = FRAME_W'({HDR, fst_q, code_q, 8'(lat_q), 8'(cnt_q)});
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      st_q <= IDLE;
      sr_q <= '0;
      bit_q <= '0;
      sdata_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      case (st_q)
        IDLE: if (ld_fall) begin
          sr_q <= frame;
          sdata_q <= frame[FRAME_W-1];
          st_q <= SHIFT;
          busy_q <= 1'b1;
        end
        SHIFT: if (ld_rise) begin
          st_q <= IDLE;
          sdata_q <= 1'b1;
          bit_q <= '0;
          busy_q <= 1'b0;
        end else if (sc_rise) begin
          sr_q <= sr_q << 1;
          if (bit_q == LAST) begin
            st_q <= DONE;
            sdata_q <= 1'b1;
            bit_q <= '0;
          end else begin
            sdata_q <= sr_q[FRAME_W-2];
            bit_q <= bit_q + BW'(1);
          end
        end
        DONE: if (ld_q[1]) begin
          st_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign oSdata = sdata_q;
  assign oBusy = busy_q;
  assign oFault_any_n = any_n_q;
  assign oFlt_latched = lat_q;
  assign oFirst_code = code_q;
  assign oFirst_state = fst_q;
  assign oFlt_cnt = cnt_q;
endmodule

// File: tb/tb_pwr_fault_logger.sv
// tb_pwr_fault_logger: scoreboard bench with a behavioural fault model and a
// serial-frame monitor that reassembles bits seen on iSclk rising edges.
`timescale 1ns/1ps
module tb_pwr_fault_logger;
  logic iClk = 0, iRst_n = 0, iClear = 0, iLoad_n = 1, iSclk = 0;
  logic [6:0] iFlt_n = '1;
  logic [3:0] iFsm_state = '0;
  logic oSdata, oFault_any_n, oBusy;
  logic [6:0] oFlt_latched;
  logic [3:0] oFirst_code, oFirst_state;
  logic [7:0] oFlt_cnt;
  pwr_fault_logger dut (
    .iClk(iClk), .iRst_n(iRst_n), .iFlt_n(iFlt_n), .iFsm_state(iFsm_state),
    .iClear(iClear), .iLoad_n(iLoad_n), .iSclk(iSclk), .oSdata(oSdata),
    .oFault_any_n(oFault_any_n), .oFlt_latched(oFlt_latched),
    .oFirst_code(oFirst_code), .oFirst_state(oFirst_state),
    .oFlt_cnt(oFlt_cnt), .oBusy(oBusy)
  );
  always #5 iClk = ~iClk;
  typedef struct {int sel; logic [31:0] exp;} chk_t;
  chk_t cq[$];
  logic [31:0] fq[$];
  int checks = 0, errors = 0;
  bit fin = 0;
  // Reference model: set of latched faults, first fault record, saturating count.
  logic [6:0] m_prev = '1, m_lat = '0;
  logic [3:0] m_code = '0, m_st = '0;
  int m_cnt = 0;
  function automatic string nm(int s);
    case (s)
      0: return "latched";
      1: return "first_code";
      2: return "first_state";
      3: return "count";
      4: return "fault_any_n";
      5: return "sdata";
      6: return "busy";
      default: return "frame";
    endcase
  endfunction
  function automatic logic [31:0] mframe();
    return {8'hA5, m_st, m_code, 1'b0, m_lat, 8'(m_cnt)};
  endfunction
  task automatic cyc();
    logic [6:0] e;
    @(posedge iClk);
    if (!iRst_n) begin
      m_prev = '1; m_lat = '0; m_code = '0; m_st = '0; m_cnt = 0;
    end else begin
      e = m_prev & ~iFlt_n;
      if (iClear) begin
        m_lat = '0; m_code = '0; m_st = '0; m_cnt = 0;
      end
      if (e != 0) begin
        if (m_code == 0) begin
          for (int i = 0; i < 7; i++) if (e[i]) begin m_code = 4'(i + 1); break; end
          m_st = iFsm_state;
        end
        m_lat |= e;
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end
      m_prev = iFlt_n;
    end
    #1 iClear = 0;
  endtask
  task automatic chk(int s, logic [31:0] e);
    cq.push_back('{s, e});
  endtask
  task automatic check_all();
    repeat (2) cyc();
    chk(0, 32'(m_lat));
    chk(1, 32'(m_code));
    chk(2, 32'(m_st));
    chk(3, 32'(m_cnt));
    chk(4, 32'(m_lat == 0));
  endtask
  task automatic read(int nb, bit noise);
    iLoad_n = 0;
    repeat (5) cyc();
    if (nb == 32) fq.push_back(mframe());
    for (int b = 0; b < nb; b++) begin
      if (noise) begin iFlt_n = 7'($urandom); iFsm_state = 4'($urandom); end
      iSclk = 1;
      repeat (4) cyc();
      if (noise) iFlt_n = 7'($urandom);
      iSclk = 0;
      repeat (4) cyc();
    end
    if (nb == 32) begin chk(5, 1); chk(6, 1); end
    iLoad_n = 1;
    repeat (5) cyc();
    chk(6, 0);
    chk(5, 1);
  endtask
  chk_t c;
  logic [31:0] act, bits = '0, ef;
  int nb = 0;
  logic sp = 0;
  always @(negedge iClk) begin
    while (cq.size() > 0) begin
      c = cq.pop_front();
      case (c.sel)
        0: act = 32'(oFlt_latched);
        1: act = 32'(oFirst_code);
        2: act = 32'(oFirst_state);
        3: act = 32'(oFlt_cnt);
        4: act = 32'(oFault_any_n);
        5: act = 32'(oSdata);
        default: act = 32'(oBusy);
      endcase
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s got=%h want=%h t=%0t", nm(c.sel), act, c.exp, $time);
      end
    end
    if (iLoad_n) nb = 0;
    else if (iSclk && !sp) begin
      bits = {bits[30:0], oSdata};
      nb++;
      if (nb == 32) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL frame got=%h want=none", bits);
        end else begin
          ef = fq.pop_front();
          if (bits !== ef) begin
            errors++;
            $display("FAIL frame got=%h want=%h t=%0t", bits, ef, $time);
          end
        end
      end
    end
    sp = iSclk;
    if (fin) begin
      checks++;
      if (fq.size() != 0) begin
        errors++;
        $display("FAIL frames_unread got=%0d want=0", fq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
  initial begin
    repeat (2) cyc();
    chk(5, 1); chk(6, 0); chk(4, 1); chk(0, 0); chk(1, 0); chk(2, 0); chk(3, 0);
    cyc();
    iRst_n = 1;
    repeat (2) cyc();
    check_all();
    read(32, 0);
    iFsm_state = 4'h5;
    iFlt_n[1] = 0;
    repeat (3) cyc();
    iFlt_n[1] = 1;
    check_all();
    iFsm_state = 4'h3;
    iFlt_n = 7'b1101110;
    cyc();
    check_all();
    read(32, 0);
    read(10, 0);
    read(32, 0);
    iFlt_n[6] = 0;
    iClear = 1;
    cyc();
    check_all();
    for (int k = 0; k < 300; k++) begin
      iFlt_n[2] = 0; cyc();
      iFlt_n[2] = 1; cyc();
    end
    check_all();
    read(32, 1);
    for (int k = 0; k < 20; k++) begin
      repeat (10) begin
        iFlt_n = 7'($urandom);
        iFsm_state = 4'($urandom);
        iClear = ($urandom_range(0, 9) == 0);
        cyc();
      end
      check_all();
      if (k % 4 == 0) read(32, 1);
    end
    iLoad_n = 0;
    repeat (5) cyc();
    repeat (3) begin
      iSclk = 1; repeat (4) cyc();
      iSclk = 0; repeat (4) cyc();
    end
    iRst_n = 0;
    iFlt_n = '1;
    chk(5, 1); chk(6, 0); chk(0, 0); chk(3, 0); chk(4, 1);
    repeat (2) cyc();
    iLoad_n = 1;
    cyc();
    iRst_n = 1;
    repeat (2) cyc();
    check_all();
    read(32, 0);
    repeat (3) cyc();
    fin = 1;
  end
endmodule

// File: doc/pwr_fault_logger.md
Name: pwr_fault_logger

Overview:
- Downstream consumer of the master power sequencer's active-low SEQPWR and RUNTIME fault flags and its 4-bit FSM state.
- Latches every fault as a sticky bit, records the first fault together with the sequencer state at that moment, and counts fault events.
- A BMC reads everything back through a simple serial frame: BMC drives load and shift clock, CPLD drives data.
- Sits beside the sequencer in the CPLD top level; the BMC-side pins are asynchronous to iClk.

Parameters:
- NUM_FLT, 7, number of active-low fault inputs; frame packing is defined for values ≤ 8.
- CNT_W, 8, fault event counter width; saturating.
- FRAME_W, 32, serial frame length in bits.
- HDR, 8'hA5, frame header byte.

Ports:
- iClk  in  1  module clock, 2 MHz
- iRst_n  in  1  asynchronous active-low reset
- iFlt_n  in  NUM_FLT  active-low faults, synchronous to iClk.
  - Bit order: 0 AUX_SEQ, 1 FAN_SEQ, 2 N1N2_SEQ, 3 PERST_SEQ, 4 AUX_RT, 5 FAN_RT, 6 N1N2_RT.
- iFsm_state  in  4  sequencer state code, synchronous to iClk
- iClear  in  1  one-cycle clear request, synchronous to iClk
- iLoad_n  in  1  BMC frame select, active-low, asynchronous
- iSclk  in  1  BMC shift clock, asynchronous, max 100 kHz
- oSdata  out  1  serial data to BMC, MSB first
- oFault_any_n  out  1  low while any sticky bit is set
- oFlt_latched  out  NUM_FLT  sticky fault bits, active-high
- oFirst_code  out  4  0 = none, else index+1 of the first fault
- oFirst_state  out  4  iFsm_state captured with the first fault
- oFlt_cnt  out  CNT_W  fault event count
- oBusy  out  1  high while the serial FSM is not IDLE

Behaviour:
- Reset values:
  - oSdata = 1, oFault_any_n = 1, oBusy = 0.
  - oFlt_latched = 0, oFirst_code = 0, oFirst_state = 0, oFlt_cnt = 0.
  - Serial FSM in IDLE; synchronizers preset to 1.
- Fault edge detection:
  - A fault edge is a 1→0 transition of an iFlt_n bit: the registered previous value is 1 and the current value is 0.
  - The previous-value register resets to all-ones, so a flag already low after reset is captured on the first clock.
- Sticky bits:
  - On an edge, set the matching oFlt_latched bit on the next iClk edge (1-cycle latency).
  - A level that stays low does not re-trigger.
  - Bits stay set after the input returns high.
- First fault:
  - Recorded only if oFirst_code == 0 when the edge is seen.
  - oFirst_code = lowest edge index + 1.
  - oFirst_state = iFsm_state sampled in the edge cycle.
  - Simultaneous edges: the lowest index wins; all of them still set sticky bits.
- Counter:
  - Increments by 1 per cycle that has at least one edge, regardless of how many edges occur in that cycle.
  - Saturates at 2^CNT_W−1.
- oFault_any_n: registered NOR of oFlt_latched.
- Clear:
  - iClear zeroes oFlt_latched, oFirst_code, oFirst_state and oFlt_cnt.
  - If an edge arrives in the same cycle as iClear, the clear is applied first and then the edge. The result holds only that new fault: count = 1, first fault recorded.
  - The previous-value register is not cleared, so faults still held low are not re-logged.
- BMC inputs: iLoad_n and iSclk each pass through a 2-FF synchronizer to iClk; edge detection uses a third registered stage.
- Serial FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - oSdata = 1.
  - On a synced iLoad_n falling edge, snapshot the frame into a shift register and go to SHIFT; oSdata = frame[31] on the following cycle.
- Frame layout: [31:24] HDR, [23:20] oFirst_state, [19:16] oFirst_code, [15:8] oFlt_latched zero-extended to 8 bits, [7:0] oFlt_cnt.
- The snapshot is taken in the same cycle as the load edge. Later fault events do not alter the frame in flight.
- SHIFT:
  - On each synced iSclk rising edge, shift left and increment a 5-bit bit counter; the BMC samples oSdata on the iSclk rising edge.
  - On the FRAME_W-th rising edge, go to DONE with oSdata = 1.
- DONE: wait for synced iLoad_n high, then go to IDLE.
- Abort: iLoad_n rising while in SHIFT means go to IDLE, oSdata = 1, bit counter = 0. Sticky state is unaffected.
- Reading does not clear faults; only iClear does.
- Serial-side reset mid-frame: outputs return to reset values immediately (asynchronous).

Test Plan:
- Reset, all iFlt_n high, one frame read → frame = 32'hA500_0000; oFault_any_n = 1.
- iFsm_state = 4'h5, pulse iFlt_n[1] low for 3 cycles → oFlt_latched = 7'h02, oFirst_code = 2, oFirst_state = 5, oFlt_cnt = 1.
- Continuing from the previous scenario: iFlt_n[4] and iFlt_n[0] fall in the same cycle with state 4'h3 → oFlt_latched = 7'h13, first fault still 2/5, count = 2.
- Continuing from the previous scenario, iClear while iFlt_n[6] falls in the same cycle → oFlt_latched = 7'h40, oFirst_code = 7, count = 1.
- 300 separate fault edges → oFlt_cnt = 8'hFF, no wrap.
- Serial read:
  - Assert iLoad_n and clock 32 iSclk pulses after the scenario-3 state → serial bits = 32'hA552_1302, then oSdata = 1.
  - Release iLoad_n after 10 clocks → FSM returns to IDLE, oBusy = 0, and the next full read is correct.
